iob_axil2iob: RTL and testbench
===============================

Name: iob_axil2iob

Overview:
- AXI4-Lite subordinate to IOb manager bridge: terminates AXI-Lite transactions from an interconnect and replays them one at a time on an IOb manager port.
- Used where an AXI-Lite host must reach native IOb peripherals. It is the counterpart of the IOb-to-AXI-Lite manager bridge.
- Holds one-deep AW/W/AR buffers, a transaction FSM, read-data capture and B/R response registers.

Parameters:
- AXIL_ADDR_W, 32, AXI-Lite and IOb address width in bits.
- AXIL_DATA_W, 32, AXI-Lite and IOb data width in bits (multiple of 8).
- TIMEOUT_W, 8, width of the watchdog counter. Used only when the optional feature is enabled.

Ports:
- clk_i  in  1  clock
- cke_i  in  1  clock enable; all registers hold while low
- arst_n_i  in  1  asynchronous reset, active low
- axil_awvalid_i  in  1  write address valid
- axil_awready_o  out  1  write address ready
- axil_awaddr_i  in  AXIL_ADDR_W  write address
- axil_awprot_i  in  3  ignored
- axil_wvalid_i  in  1  write data valid
- axil_wready_o  out  1  write data ready
- axil_wdata_i  in  AXIL_DATA_W  write data
- axil_wstrb_i  in  AXIL_DATA_W/8  write strobes
- axil_bvalid_o  out  1  write response valid
- axil_bready_i  in  1  write response ready
- axil_bresp_o  out  2  write response
- axil_arvalid_i  in  1  read address valid
- axil_arready_o  out  1  read address ready
- axil_araddr_i  in  AXIL_ADDR_W  read address
- axil_arprot_i  in  3  ignored
- axil_rvalid_o  out  1  read data valid
- axil_rready_i  in  1  read data ready
- axil_rdata_o  out  AXIL_DATA_W  read data
- axil_rresp_o  out  2  read response
- iob_valid_o  out  1  IOb request valid
- iob_addr_o  out  AXIL_ADDR_W  IOb address
- iob_wdata_o  out  AXIL_DATA_W  IOb write data
- iob_wstrb_o  out  AXIL_DATA_W/8  IOb write strobe; zero means read
- iob_ready_i  in  1  IOb request accepted
- iob_rvalid_i  in  1  IOb read data valid
- iob_rdata_i  in  AXIL_DATA_W  IOb read data
- iob_rready_o  out  1  bridge ready for IOb read data

Behaviour:
- Clock, reset and clock enable:
  - Single clock domain.
  - arst_n_i low asynchronously clears all state.
  - While in reset, every output is 0, including all ready outputs.
- Ready gating:
  - An alive flop resets to 0 and sets on the first enabled clock after reset release.
  - awready = alive & ~aw_full; wready = alive & ~w_full; arready = alive & ~ar_full.
- Buffers:
  - Each of AW, W and AR has a one-deep capture register.
  - A buffer sets its full flag on its valid&ready handshake.
  - AW and W are accepted independently, in either order or in the same cycle.
- FSM states: IDLE, WRITE, BRESP, READ, RWAIT, RRESP.
- IDLE:
  - A write is pending when aw_full & w_full. A read is pending when ar_full.
  - If both are pending, grant the opposite of last_grant. last_grant resets to READ, so the first contention goes to write.
  - Grant write -> WRITE. Grant read -> READ.
- WRITE:
  - Drive iob_valid_o=1, with addr, wdata and wstrb from the buffers.
  - On iob_ready_i: clear aw_full and w_full, set bvalid with bresp=00, go to BRESP.
- BRESP: hold bvalid until bready_i, then go to IDLE.
- Write with wstrb=0:
  - Must not appear on IOb, because it would be a read.
  - Complete it internally: go WRITE->BRESP with iob_valid_o=0, bresp=00.
- READ:
  - Drive iob_valid_o=1, iob_wstrb_o=0, iob_rready_o=1.
  - On iob_ready_i: clear ar_full.
    - If iob_rvalid_i is also high, capture rdata and go to RRESP.
    - Otherwise go to RWAIT.
- RWAIT: iob_rready_o=1. On iob_rvalid_i, capture rdata, set rresp=00, go to RRESP.
- RRESP: hold rvalid and rdata stable until rready_i, then go to IDLE.
- iob_valid_o and iob_rready_o are 0 in every other state.
- iob_addr_o, iob_wdata_o and iob_wstrb_o are 0 in IDLE and in BRESP/RRESP.
- Latency with zero-wait IOb and ready AXI:
  - AW/W handshake at cycle 0 -> iob_valid at cycle 1 -> bvalid at cycle 2.
  - AR handshake at cycle 0 -> iob_valid at cycle 1 -> rvalid at cycle 2.
- Throughput: a new AW/W/AR may be buffered while another transaction is in flight.
- Outstanding limit: at most one transaction on IOb at a time.
- iob_rvalid_i outside READ/RWAIT is ignored.
- cke_i low freezes the FSM, buffers and counters. Outputs hold their values.

Optional Feature:
- Macro: IOB_AXIL2IOB_TIMEOUT_EN.
- When defined:
  - A TIMEOUT_W-bit counter clears on entry to WRITE, READ or RWAIT and increments each cycle in those states.
  - On reaching all-ones, the bridge drops iob_valid_o/iob_rready_o and clears the corresponding buffer.
    - Write: go to BRESP with bresp=10 (SLVERR).
    - Read: go to RRESP with rdata=0, rresp=10.
- When undefined: the counter is absent and the bridge waits indefinitely. Responses are always 00.

Test Plan:
- Single write: AW addr 0x100 and W 0xDEADBEEF, wstrb 0xF, in the same cycle; IOb ready after 2 cycles -> one iob_valid pulse train with addr 0x100, wdata 0xDEADBEEF, wstrb 0xF; bvalid with bresp 00; bready held low 3 cycles keeps bvalid high.
- Single read: AR 0x204; IOb ready at cycle 1, rvalid 4 cycles later with 0x12345678 -> iob_wstrb 0, rready high in READ/RWAIT, axil rdata 0x12345678, rresp 00, stable until rready.
- Decoupled AW/W: W arrives 5 cycles before AW -> wready drops after W capture; IOb write starts only after AW; second W is stalled (wready 0) until the first write is issued.
- Contention: write and read pending in the same IDLE cycle after reset -> write issued first, then read; a repeated contention alternates.
- Reset mid-read: arst_n_i asserted in RWAIT -> all outputs 0 immediately; after release, ready outputs 0 for one cycle, then 1; no stale rvalid.
- With IOB_AXIL2IOB_TIMEOUT_EN, TIMEOUT_W=4: IOb never readies a read -> rvalid after 15 waiting cycles with rresp 10, rdata 0; a write gets bresp 10.

Source files
------------

// File: rtl/iob_axil2iob.sv
`timescale 1ns/1ps
// AXI4-Lite subordinate to IOb manager bridge: buffers AW/W/AR and replays one transaction at a time on IOb.
// Define IOB_AXIL2IOB_TIMEOUT_EN to end stalled IOb accesses with SLVERR after 2**TIMEOUT_W-1 cycles.
module iob_axil2iob #(
    parameter int AXIL_ADDR_W = 32,
    parameter int AXIL_DATA_W = 32,
    parameter int TIMEOUT_W   = 8
) (
    input  logic                       clk_i,
    input  logic                       cke_i,
    input  logic                       arst_n_i,
    input  logic                       axil_awvalid_i,
    output logic                       axil_awready_o,
    input  logic [AXIL_ADDR_W-1:0]     axil_awaddr_i,
    input  logic [2:0]                 axil_awprot_i,
    input  logic                       axil_wvalid_i,
    output logic                       axil_wready_o,
    input  logic [AXIL_DATA_W-1:0]     axil_wdata_i,
    input  logic [AXIL_DATA_W/8-1:0]   axil_wstrb_i,
    output logic                       axil_bvalid_o,
    input  logic                       axil_bready_i,
    output logic [1:0]                 axil_bresp_o,
    input  logic                       axil_arvalid_i,
    output logic                       axil_arready_o,
    input  logic [AXIL_ADDR_W-1:0]     axil_araddr_i,
    input  logic [2:0]                 axil_arprot_i,
    output logic                       axil_rvalid_o,
    input  logic                       axil_rready_i,
    output logic [AXIL_DATA_W-1:0]     axil_rdata_o,
    output logic [1:0]                 axil_rresp_o,
    output logic                       iob_valid_o,
    output logic [AXIL_ADDR_W-1:0]     iob_addr_o,
    output logic [AXIL_DATA_W-1:0]     iob_wdata_o,
    output logic [AXIL_DATA_W/8-1:0]   iob_wstrb_o,
    input  logic                       iob_ready_i,
    input  logic                       iob_rvalid_i,
    input  logic [AXIL_DATA_W-1:0]     iob_rdata_i,
    output logic                       iob_rready_o
);

    localparam int         STRB_W      = AXIL_DATA_W / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_BRESP, S_READ, S_RWAIT, S_RRESP
    } state_t;

    typedef enum logic {GRANT_WRITE, GRANT_READ} grant_t;

    state_t                 state_q, state_d;
    grant_t                 last_grant_q, last_grant_d;
    logic                   alive_q;
    logic                   aw_full_q, w_full_q, ar_full_q;
    logic [AXIL_ADDR_W-1:0] aw_addr_q, ar_addr_q;
    logic [AXIL_DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0]      w_strb_q;
    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;
    logic                   rvalid_q, rvalid_d;
    logic [AXIL_DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;
    logic                   aw_hs, w_hs, ar_hs;
    logic                   clr_wr, clr_ar;
    logic                   wr_pend, rd_pend;
    logic                   timeout_hit;
    logic                   unused_ok;

    assign unused_ok = ^{axil_awprot_i, axil_arprot_i, (TIMEOUT_W > 0)};

    assign axil_awready_o = alive_q & ~aw_full_q;
    assign axil_wready_o  = alive_q & ~w_full_q;
    assign axil_arready_o = alive_q & ~ar_full_q;

    assign aw_hs = axil_awvalid_i & axil_awready_o;
    assign w_hs  = axil_wvalid_i  & axil_wready_o;
    assign ar_hs = axil_arvalid_i & axil_arready_o;

    assign axil_bvalid_o = bvalid_q;
    assign axil_bresp_o  = bresp_q;
    assign axil_rvalid_o = rvalid_q;
    assign axil_rdata_o  = rdata_q;
    assign axil_rresp_o  = rresp_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            alive_q <= 1'b0;
        end else if (cke_i) begin
            alive_q <= 1'b1;
        end
    end

    // NOTE: buffer payloads are reset too, so no X can reach the IOb port after reset.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            ar_full_q <= 1'b0;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (cke_i) begin
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= axil_awaddr_i;
            end else if (clr_wr) begin
                aw_full_q <= 1'b0;
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= axil_wdata_i;
                w_strb_q <= axil_wstrb_i;
            end else if (clr_wr) begin
                w_full_q <= 1'b0;
            end
            if (ar_hs) begin
                ar_full_q <= 1'b1;
                ar_addr_q <= axil_araddr_i;
            end else if (clr_ar) begin
                ar_full_q <= 1'b0;
            end
        end
    end

`ifdef IOB_AXIL2IOB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q;
    logic                 in_wait;

    assign in_wait = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_RWAIT);

    // Restarts on every state change, so each waiting state gets a full budget.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            tmo_cnt_q <= '0;
        end else if (cke_i) begin
            if (state_d != state_q) begin
                tmo_cnt_q <= '0;
            end else if (in_wait) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    assign timeout_hit = in_wait && (tmo_cnt_q == '1);
`else
    assign timeout_hit = 1'b0;
`endif

    // Arbitration sees this cycle's handshakes so a request reaches IOb one cycle after acceptance.
    assign wr_pend = (aw_full_q | aw_hs) & (w_full_q | w_hs);
    assign rd_pend = ar_full_q | ar_hs;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        clr_wr       = 1'b0;
        clr_ar       = 1'b0;
        iob_valid_o  = 1'b0;
        iob_rready_o = 1'b0;
        iob_addr_o   = '0;
        iob_wdata_o  = '0;
        iob_wstrb_o  = '0;

        case (state_q)
            S_IDLE: begin
                if (wr_pend && (!rd_pend || last_grant_q == GRANT_READ)) begin
                    state_d      = S_WRITE;
                    last_grant_d = GRANT_WRITE;
                end else if (rd_pend) begin
                    state_d      = S_READ;
                    last_grant_d = GRANT_READ;
                end
            end
            S_WRITE: begin
                iob_addr_o  = aw_addr_q;
                iob_wdata_o = w_data_q;
                iob_wstrb_o = w_strb_q;
                if (w_strb_q == '0) begin
                    // An all-zero strobe would look like a read on IOb; complete it locally.
                    clr_wr   = 1'b1;
                    bvalid_d = 1'b1;
                    bresp_d  = RESP_OKAY;
                    state_d  = S_BRESP;
                end else if (timeout_hit) begin
                    clr_wr   = 1'b1;
                    bvalid_d = 1'b1;
                    bresp_d  = RESP_SLVERR;
                    state_d  = S_BRESP;
                end else begin
                    iob_valid_o = 1'b1;
                    if (iob_ready_i) begin
                        clr_wr   = 1'b1;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_OKAY;
                        state_d  = S_BRESP;
                    end
                end
            end
            S_BRESP: begin
                if (axil_bready_i) begin
                    bvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            S_READ: begin
                iob_addr_o = ar_addr_q;
                if (timeout_hit) begin
                    clr_ar   = 1'b1;
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    rresp_d  = RESP_SLVERR;
                    state_d  = S_RRESP;
                end else begin
                    iob_valid_o  = 1'b1;
                    iob_rready_o = 1'b1;
                    if (iob_ready_i) begin
                        clr_ar = 1'b1;
                        if (iob_rvalid_i) begin
                            rvalid_d = 1'b1;
                            rdata_d  = iob_rdata_i;
                            rresp_d  = RESP_OKAY;
                            state_d  = S_RRESP;
                        end else begin
                            state_d = S_RWAIT;
                        end
                    end
                end
            end
            S_RWAIT: begin
                if (timeout_hit) begin
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    rresp_d  = RESP_SLVERR;
                    state_d  = S_RRESP;
                end else begin
                    iob_rready_o = 1'b1;
                    if (iob_rvalid_i) begin
                        rvalid_d = 1'b1;
                        rdata_d  = iob_rdata_i;
                        rresp_d  = RESP_OKAY;
                        state_d  = S_RRESP;
                    end
                end
            end
            S_RRESP: begin
                if (axil_rready_i) begin
                    rvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_READ;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
        end else if (cke_i) begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
        end
    end

endmodule

// File: tb/tb_iob_axil2iob.sv
`timescale 1ns/1ps
// Scoreboard bench for iob_axil2iob: directed AXI-Lite stimulus, IOb responder model, decoupled monitors.
// Built with IOB_AXIL2IOB_TIMEOUT_EN it also exercises the watchdog with TIMEOUT_W=4.
module tb_iob_axil2iob;

    localparam int BOUND = 200;
`ifdef IOB_AXIL2IOB_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 8;
`endif

    logic        clk_i = 1'b0;
    logic        cke_i, arst_n_i;
    logic        axil_awvalid_i, axil_awready_o;
    logic [31:0] axil_awaddr_i;
    logic [2:0]  axil_awprot_i, axil_arprot_i;
    logic        axil_wvalid_i, axil_wready_o;
    logic [31:0] axil_wdata_i;
    logic [3:0]  axil_wstrb_i;
    logic        axil_bvalid_o, axil_bready_i;
    logic [1:0]  axil_bresp_o;
    logic        axil_arvalid_i, axil_arready_o;
    logic [31:0] axil_araddr_i;
    logic        axil_rvalid_o, axil_rready_i;
    logic [31:0] axil_rdata_o;
    logic [1:0]  axil_rresp_o;
    logic        iob_valid_o;
    logic [31:0] iob_addr_o, iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic        iob_ready_i, iob_rvalid_i;
    logic [31:0] iob_rdata_i;
    logic        iob_rready_o;

    always #5 clk_i = ~clk_i;

    iob_axil2iob #(.AXIL_ADDR_W(32), .AXIL_DATA_W(32), .TIMEOUT_W(TW)) dut (
        .clk_i(clk_i), .cke_i(cke_i), .arst_n_i(arst_n_i),
        .axil_awvalid_i(axil_awvalid_i), .axil_awready_o(axil_awready_o),
        .axil_awaddr_i(axil_awaddr_i), .axil_awprot_i(axil_awprot_i),
        .axil_wvalid_i(axil_wvalid_i), .axil_wready_o(axil_wready_o),
        .axil_wdata_i(axil_wdata_i), .axil_wstrb_i(axil_wstrb_i),
        .axil_bvalid_o(axil_bvalid_o), .axil_bready_i(axil_bready_i), .axil_bresp_o(axil_bresp_o),
        .axil_arvalid_i(axil_arvalid_i), .axil_arready_o(axil_arready_o),
        .axil_araddr_i(axil_araddr_i), .axil_arprot_i(axil_arprot_i),
        .axil_rvalid_o(axil_rvalid_o), .axil_rready_i(axil_rready_i),
        .axil_rdata_o(axil_rdata_o), .axil_rresp_o(axil_rresp_o),
        .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
        .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
        .iob_rdata_i(iob_rdata_i), .iob_rready_o(iob_rready_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } iob_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    iob_req_t   iob_q[$];
    logic [1:0] b_q[$];
    rsp_t       r_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    // IOb responder knobs
    int          ready_lat  = 0;
    int          rvalid_lat = 0;
    bit          iob_hang   = 1'b0;
    logic [31:0] rd_value   = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {axil_awready_o, axil_wready_o, axil_arready_o, axil_bvalid_o, axil_bresp_o,
                axil_rvalid_o, axil_rdata_o, axil_rresp_o, iob_valid_o, iob_addr_o,
                iob_wdata_o, iob_wstrb_o, iob_rready_o};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        axil_awaddr_i  = a;
        axil_awvalid_i = 1'b1;
        @(negedge clk_i);
        while (!axil_awready_o && n < BOUND) begin
            @(negedge clk_i);
            n++;
        end
        check("aw_handshake", axil_awready_o, 1);
        @(posedge clk_i);
        #1;
        axil_awvalid_i = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        axil_wdata_i  = d;
        axil_wstrb_i  = s;
        axil_wvalid_i = 1'b1;
        @(negedge clk_i);
        while (!axil_wready_o && n < BOUND) begin
            @(negedge clk_i);
            n++;
        end
        check("w_handshake", axil_wready_o, 1);
        @(posedge clk_i);
        #1;
        axil_wvalid_i = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        axil_araddr_i  = a;
        axil_arvalid_i = 1'b1;
        @(negedge clk_i);
        while (!axil_arready_o && n < BOUND) begin
            @(negedge clk_i);
            n++;
        end
        check("ar_handshake", axil_arready_o, 1);
        @(posedge clk_i);
        #1;
        axil_arvalid_i = 1'b0;
    endtask

    // Waits for bvalid (is_read=0) or rvalid (is_read=1), counting iob_valid cycles on the way.
    task automatic wait_resp(input bit is_read, output int nvalid);
        int n = 0;
        nvalid = 0;
        do begin
            @(negedge clk_i);
            if (iob_valid_o) nvalid++;
            n++;
        end while (!(is_read ? axil_rvalid_o : axil_bvalid_o) && n < BOUND);
        check(is_read ? "r_arrive" : "b_arrive", is_read ? axil_rvalid_o : axil_bvalid_o, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((iob_q.size() + b_q.size() + r_q.size()) != 0 && n < BOUND) begin
            @(negedge clk_i);
            n++;
        end
        check("drain", iob_q.size() + b_q.size() + r_q.size(), 0);
        cyc(2);
    endtask

    // IOb subordinate model, driven just after each rising edge.
    initial begin
        int req_cnt;
        int rd_cnt;
        bit rd_pend;
        req_cnt = 0;
        rd_cnt  = 0;
        rd_pend = 1'b0;
        iob_ready_i  = 1'b0;
        iob_rvalid_i = 1'b0;
        iob_rdata_i  = '0;
        forever begin
            @(posedge clk_i);
            #1;
            iob_ready_i  = 1'b0;
            iob_rvalid_i = 1'b0;
            if (!arst_n_i) begin
                req_cnt = 0;
                rd_pend = 1'b0;
            end else if (rd_pend) begin
                if (rd_cnt == 0) begin
                    iob_rvalid_i = 1'b1;
                    iob_rdata_i  = rd_value;
                    rd_pend      = 1'b0;
                end else begin
                    rd_cnt--;
                end
            end else if (iob_valid_o && !iob_hang) begin
                if (req_cnt >= ready_lat) begin
                    iob_ready_i = 1'b1;
                    req_cnt     = 0;
                    if (iob_wstrb_o == '0) begin
                        if (rvalid_lat == 0) begin
                            iob_rvalid_i = 1'b1;
                            iob_rdata_i  = rd_value;
                        end else begin
                            rd_pend = 1'b1;
                            rd_cnt  = rvalid_lat - 1;
                        end
                    end
                end else begin
                    req_cnt++;
                end
            end else begin
                req_cnt = 0;
            end
        end
    end

    // Monitors: sampled on the falling edge, compared against the expectation queues.
    initial begin
        bit         b_hold;
        bit         r_hold;
        logic [1:0] b_prev;
        rsp_t       r_prev;
        iob_req_t   ei;
        logic [1:0] eb;
        rsp_t       er;
        b_hold = 1'b0;
        r_hold = 1'b0;
        b_prev = '0;
        r_prev = '0;
        forever begin
            @(negedge clk_i);
            if (!arst_n_i) begin
                b_hold = 1'b0;
                r_hold = 1'b0;
            end else begin
                if (iob_valid_o && iob_ready_i && cke_i) begin
                    check("iob_expected", iob_q.size() > 0, 1);
                    if (iob_q.size() > 0) begin
                        ei = iob_q.pop_front();
                        check("iob_req", {iob_addr_o, iob_wdata_o, iob_wstrb_o}, ei);
                    end
                end
                if (b_hold) check("b_stable", {axil_bvalid_o, axil_bresp_o}, {1'b1, b_prev});
                if (axil_bvalid_o && axil_bready_i && cke_i) begin
                    check("b_expected", b_q.size() > 0, 1);
                    if (b_q.size() > 0) begin
                        eb = b_q.pop_front();
                        check("bresp", axil_bresp_o, eb);
                    end
                end
                b_hold = axil_bvalid_o && !(axil_bready_i && cke_i);
                b_prev = axil_bresp_o;
                if (r_hold) check("r_stable", {axil_rvalid_o, axil_rdata_o, axil_rresp_o}, {1'b1, r_prev});
                if (axil_rvalid_o && axil_rready_i && cke_i) begin
                    check("r_expected", r_q.size() > 0, 1);
                    if (r_q.size() > 0) begin
                        er = r_q.pop_front();
                        check("rdata_rresp", {axil_rdata_o, axil_rresp_o}, er);
                    end
                end
                r_hold = axil_rvalid_o && !(axil_rready_i && cke_i);
                r_prev = {axil_rdata_o, axil_rresp_o};
            end
        end
    end

    initial begin
        int nv;
        cke_i = 1'b1;
        arst_n_i = 1'b0;
        axil_awvalid_i = 1'b0; axil_awaddr_i = '0; axil_awprot_i = '0;
        axil_wvalid_i  = 1'b0; axil_wdata_i  = '0; axil_wstrb_i  = '0;
        axil_arvalid_i = 1'b0; axil_araddr_i = '0; axil_arprot_i = '0;
        axil_bready_i  = 1'b1; axil_rready_i = 1'b1;

        // Reset state and alive gating
        #2;
        check("reset_outputs", all_outs(), 0);
        cyc(2);
        check("reset_outputs_held", all_outs(), 0);
        arst_n_i = 1'b1;
        @(negedge clk_i);
        check("ready_before_alive", {axil_awready_o, axil_wready_o, axil_arready_o}, 3'b000);
        cyc(1);
        check("ready_after_alive", {axil_awready_o, axil_wready_o, axil_arready_o}, 3'b111);

        // Single write, IOb ready after two wait cycles, bready held low
        ready_lat = 2;
        axil_bready_i = 1'b0;
        iob_q.push_back('{32'h100, 32'hDEADBEEF, 4'hF});
        b_q.push_back(2'b00);
        fork
            send_aw(32'h100);
            send_w(32'hDEADBEEF, 4'hF);
        join
        wait_resp(1'b0, nv);
        check("write_valid_cycles", nv, 3);
        repeat (3) begin
            @(negedge clk_i);
            check("bvalid_held", axil_bvalid_o, 1);
        end
        cyc(1);
        axil_bready_i = 1'b1;
        cyc(2);
        check("bvalid_cleared", axil_bvalid_o, 0);

        // Zero-wait write latency
        ready_lat = 0;
        iob_q.push_back('{32'h104, 32'h0000_1234, 4'b1100});
        b_q.push_back(2'b00);
        fork
            send_aw(32'h104);
            send_w(32'h0000_1234, 4'b1100);
        join
        @(negedge clk_i);
        check("wr_lat_iob_valid", iob_valid_o, 1);
        @(negedge clk_i);
        check("wr_lat_bvalid", axil_bvalid_o, 1);
        cyc(2);

        // Single read: ready at once, rvalid four cycles later, rready held low
        rvalid_lat = 4;
        rd_value = 32'h12345678;
        axil_rready_i = 1'b0;
        iob_q.push_back('{32'h204, 32'h0, 4'h0});
        r_q.push_back('{32'h12345678, 2'b00});
        send_ar(32'h204);
        @(negedge clk_i);
        check("read_iob", {iob_valid_o, iob_wstrb_o, iob_rready_o, iob_addr_o}, {1'b1, 4'h0, 1'b1, 32'h204});
        @(negedge clk_i);
        check("rwait_iob", {iob_valid_o, iob_rready_o}, 2'b01);
        wait_resp(1'b1, nv);
        repeat (2) @(negedge clk_i);
        cyc(1);
        axil_rready_i = 1'b1;
        cyc(2);
        check("rvalid_cleared", axil_rvalid_o, 0);

        // Zero-wait read latency
        rvalid_lat = 0;
        rd_value = 32'hA5A5_0001;
        iob_q.push_back('{32'h208, 32'h0, 4'h0});
        r_q.push_back('{32'hA5A5_0001, 2'b00});
        send_ar(32'h208);
        @(negedge clk_i);
        check("rd_lat_iob_valid", iob_valid_o, 1);
        @(negedge clk_i);
        check("rd_lat_rvalid", axil_rvalid_o, 1);
        cyc(2);

        // Write with zero strobe completes without touching IOb
        b_q.push_back(2'b00);
        fork
            send_aw(32'h300);
            send_w(32'h1111_1111, 4'h0);
        join
        @(negedge clk_i);
        check("zstrb_no_iob", iob_valid_o, 0);
        @(negedge clk_i);
        check("zstrb_bvalid", {axil_bvalid_o, axil_bresp_o}, 3'b100);
        wait_drain();

        // Decoupled AW/W: W five cycles early, second W stalled behind the first write
        ready_lat = 3;
        iob_q.push_back('{32'h400, 32'hCAFE0001, 4'hF});
        b_q.push_back(2'b00);
        iob_q.push_back('{32'h404, 32'hCAFE0002, 4'b0011});
        b_q.push_back(2'b00);
        send_w(32'hCAFE0001, 4'hF);
        check("w_only_stall", {axil_wready_o, iob_valid_o}, 2'b00);
        cyc(4);
        check("w_only_no_iob", {axil_wready_o, axil_awready_o, iob_valid_o}, 3'b010);
        send_aw(32'h400);
        axil_wdata_i = 32'hCAFE0002;
        axil_wstrb_i = 4'b0011;
        axil_wvalid_i = 1'b1;
        @(negedge clk_i);
        check("w2_stalled", {axil_wready_o, iob_valid_o}, 2'b01);
        cyc(1);
        send_w(32'hCAFE0002, 4'b0011);
        send_aw(32'h404);
        wait_drain();

        // Reset asserted while waiting for IOb read data
        ready_lat = 0;
        rvalid_lat = 20;
        iob_q.push_back('{32'h500, 32'h0, 4'h0});
        send_ar(32'h500);
        cyc(3);
        check("in_rwait", {iob_valid_o, iob_rready_o}, 2'b01);
        #2;
        arst_n_i = 1'b0;
        #1;
        check("reset_mid_read", all_outs(), 0);
        cyc(2);
        arst_n_i = 1'b1;
        @(negedge clk_i);
        check("ready_after_reset_low", {axil_awready_o, axil_wready_o, axil_arready_o}, 3'b000);
        cyc(1);
        check("ready_after_reset_high", {axil_awready_o, axil_wready_o, axil_arready_o, axil_rvalid_o}, 4'b1110);
        cyc(3);
        check("no_stale_rvalid", axil_rvalid_o, 0);

        // Contention right after reset: write first, then read
        rvalid_lat = 1;
        rd_value = 32'h0BADF00D;
        iob_q.push_back('{32'h600, 32'h600D600D, 4'hF});
        iob_q.push_back('{32'h604, 32'h0, 4'h0});
        b_q.push_back(2'b00);
        r_q.push_back('{32'h0BADF00D, 2'b00});
        fork
            send_aw(32'h600);
            send_w(32'h600D600D, 4'hF);
            send_ar(32'h604);
        join
        wait_drain();

        // A lone write, then contention again: read now wins
        iob_q.push_back('{32'h608, 32'h0000_0008, 4'h1});
        b_q.push_back(2'b00);
        fork
            send_aw(32'h608);
            send_w(32'h0000_0008, 4'h1);
        join
        wait_drain();
        rd_value = 32'hFEED_0C0C;
        iob_q.push_back('{32'h60C, 32'h0, 4'h0});
        iob_q.push_back('{32'h610, 32'h7777_8888, 4'b1000});
        b_q.push_back(2'b00);
        r_q.push_back('{32'hFEED_0C0C, 2'b00});
        fork
            send_aw(32'h610);
            send_w(32'h7777_8888, 4'b1000);
            send_ar(32'h60C);
        join
        wait_drain();

        // Clock enable low freezes a pending write response
        axil_bready_i = 1'b0;
        iob_q.push_back('{32'h800, 32'h0000_00FF, 4'b0001});
        b_q.push_back(2'b00);
        fork
            send_aw(32'h800);
            send_w(32'h0000_00FF, 4'b0001);
        join
        wait_resp(1'b0, nv);
        cyc(1);
        cke_i = 1'b0;
        axil_bready_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check("cke_freeze_bvalid", axil_bvalid_o, 1);
        end
        cyc(1);
        cke_i = 1'b1;
        wait_drain();

`ifdef IOB_AXIL2IOB_TIMEOUT_EN
        // IOb never answers: read and write end with SLVERR
        iob_hang = 1'b1;
        r_q.push_back('{32'h0, 2'b10});
        send_ar(32'h700);
        wait_resp(1'b1, nv);
        check("tmo_read_valid_cycles", nv, 15);
        wait_drain();
        b_q.push_back(2'b10);
        fork
            send_aw(32'h704);
            send_w(32'h1234_5678, 4'hF);
        join
        wait_resp(1'b0, nv);
        check("tmo_write_valid_cycles", nv, 15);
        wait_drain();
        iob_hang = 1'b0;
`endif

        check("iob_queue_empty", iob_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
